// File: rtl/input_ctrl.sv
// input_ctrl: synchronise, debounce and edge-detect board buttons and DIP switches.
// Change pulses stay quiet until the post-reset settle window has elapsed.
module input_ctrl #(
    parameter int N_BTN    = 4,
    parameter int N_SW     = 8,
    parameter int BTN_INV  = 1,
    parameter int TICK_DIV = 14,
    parameter int DB_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_SW-1:0]  dip_sw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rel,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_changed,
    output logic             valid
);
    localparam int N  = N_BTN + N_SW;
    localparam int CW = $clog2(DB_TICKS);
    localparam logic [N-1:0] INV = {{N_SW{1'b0}}, {N_BTN{BTN_INV != 0}}};
    logic [N-1:0]        sync1, sync2, s, stable, chg, ev;
    logic [CW-1:0]       cnt [N];
    logic [TICK_DIV-1:0] pre;
    logic [7:0]          settle;
    logic                tick;
    assign s    = sync2 ^ INV;
    assign tick = &pre;
    // ev marks the tick on which an input completes its run of differing samples
    always_comb begin
        ev = '0;
        for (int i = 0; i < N; i++)
            ev[i] = tick && s[i] != stable[i] && cnt[i] == CW'(DB_TICKS - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            chg    <= '0;
            pre    <= '0;
            settle <= '0;
            valid  <= 1'b0;
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
        end else begin
            sync1  <= {dip_sw, btn};
            sync2  <= sync1;
            pre    <= pre + TICK_DIV'(1);
            chg    <= valid ? ev : '0;
            stable <= stable ^ ev;
            if (tick && !valid) begin
                settle <= settle + 8'd1;
                valid  <= settle == 8'(DB_TICKS - 1);
            end
            for (int i = 0; i < N; i++)
                if (tick)
                    cnt[i] <= (s[i] == stable[i] || ev[i]) ? '0 : cnt[i] + CW'(1);
        end
    end
    assign btn_level  = stable[N_BTN-1:0];
    assign sw_level   = stable[N-1:N_BTN];
    assign btn_press  = chg[N_BTN-1:0] & btn_level;
    assign btn_rel    = chg[N_BTN-1:0] & ~btn_level;
    assign sw_changed = chg[N-1:N_BTN];
endmodule
